// File: rtl/alu_md_pkg.sv
// Shared definitions for alu_md: op encoding, FSM state type and op-class helpers.
package alu_md_pkg;

   localparam logic [4:0] OP_ADD    = 5'h00;
   localparam logic [4:0] OP_SUB    = 5'h01;
   localparam logic [4:0] OP_XOR    = 5'h02;
   localparam logic [4:0] OP_OR     = 5'h03;
   localparam logic [4:0] OP_AND    = 5'h04;
   localparam logic [4:0] OP_SLL    = 5'h05;
   localparam logic [4:0] OP_SRL    = 5'h06;
   localparam logic [4:0] OP_SRA    = 5'h07;
   localparam logic [4:0] OP_SLT    = 5'h08;
   localparam logic [4:0] OP_SLTU   = 5'h09;
   localparam logic [4:0] OP_BEQ    = 5'h0A;
   localparam logic [4:0] OP_BNE    = 5'h0B;
   localparam logic [4:0] OP_BLT    = 5'h0C;
   localparam logic [4:0] OP_BGE    = 5'h0D;
   localparam logic [4:0] OP_BLTU   = 5'h0E;
   localparam logic [4:0] OP_BGEU   = 5'h0F;
   localparam logic [4:0] OP_MUL    = 5'h10;
   localparam logic [4:0] OP_MULH   = 5'h11;
   localparam logic [4:0] OP_MULHSU = 5'h12;
   localparam logic [4:0] OP_MULHU  = 5'h13;
   localparam logic [4:0] OP_DIV    = 5'h14;
   localparam logic [4:0] OP_DIVU   = 5'h15;
   localparam logic [4:0] OP_REM    = 5'h16;
   localparam logic [4:0] OP_REMU   = 5'h17;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic is_mul(input logic [4:0] op);
      return (op >= OP_MUL) && (op <= OP_MULHU);
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return (op >= OP_DIV) && (op <= OP_REMU);
   endfunction

endpackage

// File: rtl/alu_md_div.sv
// Iterative restoring divider: one quotient bit per cycle, XLEN cycles total,
// signed operation on magnitudes with the sign applied to the final outputs.
module alu_md_div #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            is_signed,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0]  rem_q, quo_q, dsr_q, dvd_q;
   logic             neg_q, neg_r, dz_q, active;
   logic [CNT_W-1:0] cnt;

   logic             a_neg, b_neg, ge;
   logic [XLEN-1:0]  mag_a, mag_b, src_r, src_q, src_d, rem_n, quo_n;
   logic [XLEN:0]    shifted;
   logic [XLEN+1:0]  diff;

   // The start cycle already performs the first iteration on the fresh operands.
   always_comb begin
      a_neg   = is_signed & dividend[XLEN-1];
      b_neg   = is_signed & divisor[XLEN-1];
      mag_a   = a_neg ? -dividend : dividend;
      mag_b   = b_neg ? -divisor : divisor;
      src_r   = start ? '0 : rem_q;
      src_q   = start ? mag_a : quo_q;
      src_d   = start ? mag_b : dsr_q;
      shifted = {src_r, src_q[XLEN-1]};
      diff    = {1'b0, shifted} - {2'b00, src_d};
      ge      = ~diff[XLEN+1];
      rem_n   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_n   = {src_q[XLEN-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dsr_q  <= '0;
         dvd_q  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz_q   <= 1'b0;
         active <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem_q  <= rem_n;
            quo_q  <= quo_n;
            dsr_q  <= mag_b;
            dvd_q  <= dividend;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz_q   <= (divisor == '0);
            cnt    <= CNT_W'(XLEN - 1);
            active <= 1'b1;
         end else if (active) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt   <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

   // Most-negative / -1 needs no special case: the magnitude quotient negates back to itself.
   always_comb begin
      quotient  = dz_q ? '1 : (neg_q ? -quo_q : quo_q);
      remainder = dz_q ? dvd_q : (neg_r ? -rem_q : rem_q);
   end

endmodule

// File: rtl/alu_md.sv
// RV32I/RV64I ALU with M-extension multiply/divide behind a valid/ready handshake.
// Define ALU_MD_FAST_MUL_EN for a single-cycle multiplier instead of the iterative one.
module alu_md
   import alu_md_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            br
);

   localparam int SHW = $clog2(XLEN);

   state_t          state;
   logic [4:0]      op_q;
   logic            accept, multi, finish;
   logic [XLEN-1:0] alu_res, sc_res, busy_res, div_res;
   logic            alu_br;

   logic            div_done;
   logic [XLEN-1:0] div_quo, div_rem;

   logic            ma_neg, mb_neg;
   logic [XLEN-1:0] mul_mag_a, mul_mag_b;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && (state == IDLE);

   always_comb begin
      alu_res = '0;
      alu_br  = 1'b0;
      case (op)
         OP_ADD:  alu_res = data1_i + data2_i;
         OP_SUB:  alu_res = data1_i - data2_i;
         OP_XOR:  alu_res = data1_i ^ data2_i;
         OP_OR:   alu_res = data1_i | data2_i;
         OP_AND:  alu_res = data1_i & data2_i;
         OP_SLL:  alu_res = data1_i << data2_i[SHW-1:0];
         OP_SRL:  alu_res = data1_i >> data2_i[SHW-1:0];
         OP_SRA:  alu_res = $signed(data1_i) >>> data2_i[SHW-1:0];
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, data1_i < data2_i};
         OP_BEQ:  alu_br  = (data1_i == data2_i);
         OP_BNE:  alu_br  = (data1_i != data2_i);
         OP_BLT:  alu_br  = ($signed(data1_i) < $signed(data2_i));
         OP_BGE:  alu_br  = ($signed(data1_i) >= $signed(data2_i));
         OP_BLTU: alu_br  = (data1_i < data2_i);
         OP_BGEU: alu_br  = (data1_i >= data2_i);
         default: ;
      endcase
   end

   // Multiplies also run on magnitudes; the product is negated when the operand signs differ.
   always_comb begin
      ma_neg    = data1_i[XLEN-1] & ((op == OP_MULH) || (op == OP_MULHSU));
      mb_neg    = data2_i[XLEN-1] & (op == OP_MULH);
      mul_mag_a = ma_neg ? -data1_i : data1_i;
      mul_mag_b = mb_neg ? -data2_i : data2_i;
   end

   alu_md_div #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (accept && is_div(op)),
      .dividend  (data1_i),
      .divisor   (data2_i),
      .is_signed ((op == OP_DIV) || (op == OP_REM)),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? div_quo : div_rem;

`ifdef ALU_MD_FAST_MUL_EN
   logic [2*XLEN-1:0] prod_mag, prod;
   logic [XLEN-1:0]   mul_res;

   always_comb begin
      prod_mag = {{XLEN{1'b0}}, mul_mag_a} * {{XLEN{1'b0}}, mul_mag_b};
      prod     = (ma_neg ^ mb_neg) ? -prod_mag : prod_mag;
      mul_res  = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      sc_res   = is_mul(op) ? mul_res : alu_res;
      multi    = is_div(op);
      busy_res = div_res;
      finish   = div_done;
   end
`else
   logic [2*XLEN-1:0] acc, mcand, prod;
   logic [XLEN-1:0]   mplier, mul_res;
   logic              mneg;
   logic [CNT_W-1:0]  cnt;

   // Shift-add: bit 0 of the multiplier is consumed at acceptance, the rest in BUSY.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         mneg   <= 1'b0;
         cnt    <= '0;
      end else if (accept && is_mul(op)) begin
         acc    <= mul_mag_b[0] ? {{XLEN{1'b0}}, mul_mag_a} : '0;
         mcand  <= {{(XLEN-1){1'b0}}, mul_mag_a, 1'b0};
         mplier <= mul_mag_b >> 1;
         mneg   <= ma_neg ^ mb_neg;
         cnt    <= CNT_W'(XLEN - 1);
      end else if ((state == BUSY) && (cnt != '0)) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - 1'b1;
      end
   end

   always_comb begin
      prod     = mneg ? -acc : acc;
      mul_res  = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      sc_res   = alu_res;
      multi    = is_div(op) || is_mul(op);
      busy_res = is_div(op_q) ? div_res : mul_res;
      finish   = is_div(op_q) ? div_done : (cnt == '0);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         br        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q <= op;
                  if (multi) begin
                     state <= BUSY;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= sc_res;
                     br        <= alu_br;
                  end
               end
            end
            BUSY: begin
               if (finish) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= busy_res;
                  br        <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (legal values 32 or 64).
REQ-002 SHALL have parameter CNT_W, default $clog2(XLEN)+1, meaning iteration counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  5  operation code (shared package encoding).
REQ-008 SHALL have ports data1_i, data2_i  input  XLEN  operands rs1 and rs2/imm.
REQ-009 SHALL have port out_valid  output  1  result/br valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  XLEN  registered result.
REQ-012 SHALL have port br  output  1  registered branch-taken flag.

Function
REQ-013 op 0x00-0x09 SHALL be ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU with RV32I semantics; shift amount data2_i[$clog2(XLEN)-1:0].
REQ-014 op 0x0A-0x0F SHALL be BEQ, BNE, BLT, BGE, BLTU, BGEU: br per RV compare, result = 0.
REQ-015 op 0x10-0x17 SHALL be MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU with RV M-extension semantics; br = 0 for all non-branch ops.
REQ-016 Undefined op (0x18-0x1F) SHALL complete as a single-cycle op with result = 0, br = 0.
REQ-017 FSM states SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-018 Handshake: request accepted on cycle where in_valid && in_ready; operands and op captured that cycle.
REQ-019 Single-cycle ops (base, branch, undefined) SHALL go IDLE->DONE; out_valid asserted the cycle after acceptance.
REQ-020 Divide ops SHALL go IDLE->BUSY, iterate exactly XLEN cycles (one quotient bit per cycle), then BUSY->DONE; out_valid at acceptance+XLEN+1.
REQ-021 DONE SHALL hold result, br, out_valid stable until out_valid && out_ready, then go to IDLE next cycle.
REQ-022 Divide by zero SHALL return quotient all-ones, remainder = dividend, full XLEN iterations still taken.
REQ-023 Signed overflow (most-negative / -1) SHALL return quotient = dividend, remainder = 0.
REQ-024 Signed divide SHALL operate on magnitudes and fix sign at completion: quotient negative iff signs differ, remainder takes dividend sign.
REQ-025 in_valid and op/operand changes while not in IDLE SHALL be ignored.

Reset
REQ-026 rst SHALL force state IDLE, out_valid = 0, result = 0, br = 0, counter = 0 on the next edge, aborting any in-flight operation; in_ready = 1 the cycle after rst deasserts.

Configuration
REQ-027 With ALU_MD_FAST_MUL_EN defined, multiply ops SHALL be single-cycle (IDLE->DONE, out_valid at acceptance+1) using a full 2*XLEN product.
REQ-028 Without ALU_MD_FAST_MUL_EN, multiply ops SHALL use iterative shift-add, XLEN cycles in BUSY, out_valid at acceptance+XLEN+1; results identical to fast mode.

Structure
REQ-029 Package alu_md_pkg SHALL hold the op encoding constants and the FSM state type.
REQ-030 The iterative restoring divider SHALL be sub-module alu_md_div (start, operands, signed flag -> done, quotient, remainder).

Verification
REQ-031 ADD 0x7FFFFFFF + 1 accepted at cycle 0 -> out_valid cycle 1, result 0x80000000, br 0.
REQ-032 BLT data1 0xFFFFFFFF, data2 0x00000001 -> br 1, result 0; BLTU same operands -> br 0.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000 at cycle XLEN+1; REM same -> 0.
REQ-034 DIVU 7 / 0 -> 0xFFFFFFFF; REMU 7 / 0 -> 7; REM -7 / 2 -> 0xFFFFFFFF.
REQ-035 MULH 0x80000000 * 0x80000000 -> 0x40000000; latency 1 with ALU_MD_FAST_MUL_EN, 33 without.
REQ-036 out_ready held 0 for 5 cycles after DONE -> result stable, in_ready 0; rst asserted mid-DIV -> out_valid 0, in_ready 1 after release.
